// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes the ALU op, selects operand b and holds one entry for execute.
// Optional operand forwarding (capture and stall re-evaluation) is enabled by defining ID_EX_FWD_EN.
module id_ex_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [4:0]      in_rd,
    input  logic [1:0]      in_aluop,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7_5,
    input  logic            in_alusrc,
    input  logic [4:0]      in_ctrl,
    input  logic            flush,
`ifdef ID_EX_FWD_EN
    input  logic            fwd_em_we,
    input  logic [4:0]      fwd_em_rd,
    input  logic [XLEN-1:0] fwd_em_data,
    input  logic            fwd_mw_we,
    input  logic [4:0]      fwd_mw_rd,
    input  logic [XLEN-1:0] fwd_mw_data,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [3:0]      out_alu_op,
    output logic [XLEN-1:0] out_store_data,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_ctrl,
    output logic            out_illegal
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] st_q, st_d;
    logic [3:0]      op_q, op_d;
    logic            ill_q, ill_d;
    logic [4:0]      rs1_q, rs1_d;
    logic [4:0]      rs2_q, rs2_d;
    logic [4:0]      rd_q, rd_d;
    logic [4:0]      ctrl_q, ctrl_d;

    logic [3:0]      dec_op;
    logic            dec_ill;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            capture;

`ifdef ID_EX_FWD_EN
    logic alusrc_q, alusrc_d;

    // EX/MEM is the younger producer, so it takes priority over MEM/WB.
    function automatic logic [XLEN-1:0] fwd_sel(input logic [4:0] idx, input logic [XLEN-1:0] dflt);
        if (fwd_em_we && (fwd_em_rd != 5'd0) && (fwd_em_rd == idx))
            return fwd_em_data;
        else if (fwd_mw_we && (fwd_mw_rd != 5'd0) && (fwd_mw_rd == idx))
            return fwd_mw_data;
        else
            return dflt;
    endfunction

    assign rs1_val = fwd_sel(in_rs1, in_rs1_data);
    assign rs2_val = fwd_sel(in_rs2, in_rs2_data);
`else
    assign rs1_val = in_rs1_data;
    assign rs2_val = in_rs2_data;
`endif

    assign in_ready = !valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    always_comb begin
        dec_op  = 4'b1111;
        dec_ill = 1'b1;
        case (in_aluop)
            2'b00: begin dec_op = 4'b0010; dec_ill = 1'b0; end
            2'b01: begin dec_op = 4'b0110; dec_ill = 1'b0; end
            2'b10, 2'b11: begin
                case (in_funct3)
                    3'b000: begin
                        // Only R-type uses bit 30 to pick sub; addi ignores it.
                        dec_op  = (in_aluop == 2'b10 && in_funct7_5) ? 4'b0110 : 4'b0010;
                        dec_ill = 1'b0;
                    end
                    3'b111:  begin dec_op = 4'b0000; dec_ill = 1'b0; end
                    3'b110:  begin dec_op = 4'b0001; dec_ill = 1'b0; end
                    default: begin dec_op = 4'b1111; dec_ill = 1'b1; end
                endcase
            end
            default: begin dec_op = 4'b1111; dec_ill = 1'b1; end
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        st_d    = st_q;
        op_d    = op_q;
        ill_d   = ill_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
`ifdef ID_EX_FWD_EN
        alusrc_d = alusrc_q;
`endif
        if (flush) begin
            valid_d = 1'b0;
            ill_d   = 1'b0;
        end else if (capture) begin
            valid_d = 1'b1;
            a_d     = rs1_val;
            b_d     = in_alusrc ? in_imm : rs2_val;
            st_d    = rs2_val;
            op_d    = dec_op;
            ill_d   = dec_ill;
            rs1_d   = in_rs1;
            rs2_d   = in_rs2;
            rd_d    = in_rd;
            ctrl_d  = in_ctrl;
`ifdef ID_EX_FWD_EN
            alusrc_d = in_alusrc;
`endif
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
`ifdef ID_EX_FWD_EN
            // A stalled entry keeps picking up results that retire while it waits.
            a_d  = fwd_sel(rs1_q, a_q);
            st_d = fwd_sel(rs2_q, st_q);
            if (!alusrc_q)
                b_d = fwd_sel(rs2_q, b_q);
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            st_q    <= '0;
            op_q    <= 4'b0000;
            ill_q   <= 1'b0;
            rs1_q   <= 5'd0;
            rs2_q   <= 5'd0;
            rd_q    <= 5'd0;
            ctrl_q  <= 5'd0;
`ifdef ID_EX_FWD_EN
            alusrc_q <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            st_q    <= st_d;
            op_q    <= op_d;
            ill_q   <= ill_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
`ifdef ID_EX_FWD_EN
            alusrc_q <= alusrc_d;
`endif
        end
    end

    assign out_valid      = valid_q;
    assign out_a          = a_q;
    assign out_b          = b_q;
    assign out_store_data = st_q;
    assign out_alu_op     = op_q;
    assign out_illegal    = ill_q;
    assign out_rs1        = rs1_q;
    assign out_rs2        = rs2_q;
    assign out_rd         = rd_q;
    assign out_ctrl       = ctrl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: decode vector table, handshake corner sequences and a randomized run
// against a transaction-level model of the stage. Forwarding checks run when ID_EX_FWD_EN is defined.
module tb_id_ex_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [1:0]  in_aluop;
    logic [2:0]  in_funct3;
    logic        in_funct7_5;
    logic        in_alusrc;
    logic [4:0]  in_ctrl;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_a, out_b, out_store_data;
    logic [3:0]  out_alu_op;
    logic [4:0]  out_rs1, out_rs2, out_rd, out_ctrl;
    logic        out_illegal;
`ifdef ID_EX_FWD_EN
    logic        fwd_em_we, fwd_mw_we;
    logic [4:0]  fwd_em_rd, fwd_mw_rd;
    logic [63:0] fwd_em_data, fwd_mw_data;
`endif

    int checks = 0;
    int failures = 0;

    id_ex_stage #(.XLEN(64)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_aluop(in_aluop), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
        .in_alusrc(in_alusrc), .in_ctrl(in_ctrl), .flush(flush),
`ifdef ID_EX_FWD_EN
        .fwd_em_we(fwd_em_we), .fwd_em_rd(fwd_em_rd), .fwd_em_data(fwd_em_data),
        .fwd_mw_we(fwd_mw_we), .fwd_mw_rd(fwd_mw_rd), .fwd_mw_data(fwd_mw_data),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_alu_op(out_alu_op),
        .out_store_data(out_store_data),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_ctrl(out_ctrl), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    // Reference model: the instruction currently held by the stage.
    typedef struct {
        logic        valid;
        logic [63:0] a, b, st;
        logic [3:0]  op;
        logic        ill;
        logic [4:0]  rs1, rs2, rd, ctrl;
    } entry_t;
    entry_t m;

    typedef struct {
        logic [1:0]  aluop;
        logic [2:0]  f3;
        logic        f7;
        logic        alusrc;
        logic [63:0] rs1d, rs2d, imm;
        logic [3:0]  exp_op;
        logic        exp_ill;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ALU op meaning: mem=add, branch=sub, add/sub/and/or for R-type, addi/andi/ori for I-type.
    function automatic void ref_decode(input logic [1:0] aluop, input logic [2:0] f3, input logic f7,
                                       output logic [3:0] op, output logic ill);
        op  = 4'b1111;
        ill = 1'b1;
        if (aluop == 2'b00) begin op = 4'b0010; ill = 1'b0; end
        else if (aluop == 2'b01) begin op = 4'b0110; ill = 1'b0; end
        else if (f3 == 3'b111) begin op = 4'b0000; ill = 1'b0; end
        else if (f3 == 3'b110) begin op = 4'b0001; ill = 1'b0; end
        else if (f3 == 3'b000) begin
            op  = (aluop == 2'b10 && f7) ? 4'b0110 : 4'b0010;
            ill = 1'b0;
        end
    endfunction

    task automatic model_reset();
        m = '{valid: 1'b0, a: 64'd0, b: 64'd0, st: 64'd0, op: 4'd0, ill: 1'b0,
              rs1: 5'd0, rs2: 5'd0, rd: 5'd0, ctrl: 5'd0};
    endtask

    task automatic model_edge();
        logic [3:0] op;
        logic       ill;
        if (flush) begin
            m.valid = 1'b0;
            m.ill   = 1'b0;
        end else if (in_valid && (!m.valid || out_ready)) begin
            ref_decode(in_aluop, in_funct3, in_funct7_5, op, ill);
            m.valid = 1'b1;
            m.a     = in_rs1_data;
            m.b     = in_alusrc ? in_imm : in_rs2_data;
            m.st    = in_rs2_data;
            m.op    = op;
            m.ill   = ill;
            m.rs1   = in_rs1;
            m.rs2   = in_rs2;
            m.rd    = in_rd;
            m.ctrl  = in_ctrl;
        end else if (m.valid && out_ready) begin
            m.valid = 1'b0;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input int cyc);
        check($sformatf("rnd%0d_valid", cyc), out_valid, m.valid);
        check($sformatf("rnd%0d_in_ready", cyc), in_ready, !m.valid || out_ready);
        check($sformatf("rnd%0d_a", cyc), out_a, m.a);
        check($sformatf("rnd%0d_b", cyc), out_b, m.b);
        check($sformatf("rnd%0d_store", cyc), out_store_data, m.st);
        check($sformatf("rnd%0d_op", cyc), out_alu_op, m.op);
        check($sformatf("rnd%0d_illegal", cyc), out_illegal, m.ill);
        check($sformatf("rnd%0d_idx", cyc), {out_rs1, out_rs2, out_rd}, {m.rs1, m.rs2, m.rd});
        check($sformatf("rnd%0d_ctrl", cyc), out_ctrl, m.ctrl);
    endtask

    task automatic set_instr(input logic [1:0] aluop, input logic [2:0] f3, input logic f7,
                             input logic alusrc, input logic [63:0] rs1d, input logic [63:0] rs2d,
                             input logic [63:0] imm);
        in_aluop    = aluop;
        in_funct3   = f3;
        in_funct7_5 = f7;
        in_alusrc   = alusrc;
        in_rs1_data = rs1d;
        in_rs2_data = rs2d;
        in_imm      = imm;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        set_instr(2'b00, 3'b000, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
        in_rs1 = 5'd1; in_rs2 = 5'd2; in_rd = 5'd3; in_ctrl = 5'b00001;
`ifdef ID_EX_FWD_EN
        fwd_em_we = 1'b0; fwd_em_rd = 5'd0; fwd_em_data = 64'd0;
        fwd_mw_we = 1'b0; fwd_mw_rd = 5'd0; fwd_mw_data = 64'd0;
`endif
        model_reset();

        vecs[0]  = '{2'b00, 3'b101, 1'b1, 1'b1, 64'd10, 64'd20, 64'd8,   4'b0010, 1'b0};
        vecs[1]  = '{2'b01, 3'b001, 1'b0, 1'b0, 64'd11, 64'd21, 64'd0,   4'b0110, 1'b0};
        vecs[2]  = '{2'b10, 3'b000, 1'b0, 1'b0, 64'd12, 64'd22, 64'd0,   4'b0010, 1'b0};
        vecs[3]  = '{2'b10, 3'b000, 1'b1, 1'b0, 64'd5,  64'd3,  64'd0,   4'b0110, 1'b0};
        vecs[4]  = '{2'b10, 3'b111, 1'b0, 1'b0, 64'd13, 64'd23, 64'd0,   4'b0000, 1'b0};
        vecs[5]  = '{2'b10, 3'b110, 1'b0, 1'b0, 64'd14, 64'd24, 64'd0,   4'b0001, 1'b0};
        vecs[6]  = '{2'b11, 3'b000, 1'b1, 1'b1, 64'd15, 64'd25, 64'd7,   4'b0010, 1'b0};
        vecs[7]  = '{2'b11, 3'b111, 1'b0, 1'b1, 64'd16, 64'h77, 64'hFFFF_FFFF_FFFF_FFF0, 4'b0000, 1'b0};
        vecs[8]  = '{2'b11, 3'b110, 1'b0, 1'b1, 64'd17, 64'd27, 64'h100, 4'b0001, 1'b0};
        vecs[9]  = '{2'b10, 3'b001, 1'b0, 1'b0, 64'd18, 64'd28, 64'd0,   4'b1111, 1'b1};
        vecs[10] = '{2'b11, 3'b101, 1'b0, 1'b1, 64'd19, 64'd29, 64'd4,   4'b1111, 1'b1};
        vecs[11] = '{2'b10, 3'b100, 1'b1, 1'b0, 64'd30, 64'd31, 64'd0,   4'b1111, 1'b1};

        // Reset state, observed while reset is still asserted.
        #2;
        check("reset_valid", out_valid, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_op", out_alu_op, 4'b0000);
        check("reset_illegal", out_illegal, 1'b0);
        check("reset_data", out_a | out_b | out_store_data, 64'd0);
        check("reset_idx_ctrl", {out_rs1, out_rs2, out_rd, out_ctrl}, 20'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Decode table: one instruction per cycle with out_ready held high.
        for (int i = 0; i < 12; i++) begin
            set_instr(vecs[i].aluop, vecs[i].f3, vecs[i].f7, vecs[i].alusrc,
                      vecs[i].rs1d, vecs[i].rs2d, vecs[i].imm);
            in_rd = 5'(i + 1);
            in_valid = 1'b1;
            step();
            $display("vec %0d aluop=%b f3=%b f7=%b -> op=%b ill=%b a=%0h b=%0h", i,
                     vecs[i].aluop, vecs[i].f3, vecs[i].f7, out_alu_op, out_illegal, out_a, out_b);
            check($sformatf("vec%0d_valid", i), out_valid, 1'b1);
            check($sformatf("vec%0d_op", i), out_alu_op, vecs[i].exp_op);
            check($sformatf("vec%0d_illegal", i), out_illegal, vecs[i].exp_ill);
            check($sformatf("vec%0d_a", i), out_a, vecs[i].rs1d);
            check($sformatf("vec%0d_b", i), out_b, vecs[i].alusrc ? vecs[i].imm : vecs[i].rs2d);
            check($sformatf("vec%0d_store", i), out_store_data, vecs[i].rs2d);
            check($sformatf("vec%0d_rd", i), out_rd, 5'(i + 1));
        end

        // Stall for 3 cycles, then release: the waiting instruction enters on the release edge.
        set_instr(2'b00, 3'b000, 1'b0, 1'b0, 64'h111, 64'h1, 64'h0);
        step();
        out_ready = 1'b0;
        set_instr(2'b00, 3'b000, 1'b0, 1'b0, 64'h222, 64'h2, 64'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            $display("stall cycle %0d valid=%b in_ready=%b a=%0h", i, out_valid, in_ready, out_a);
            check($sformatf("stall%0d_in_ready", i), in_ready, 1'b0);
            check($sformatf("stall%0d_valid", i), out_valid, 1'b1);
            check($sformatf("stall%0d_hold_a", i), out_a, 64'h111);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1'b1);
        step();
        $display("release valid=%b a=%0h", out_valid, out_a);
        check("release_valid", out_valid, 1'b1);
        check("release_a", out_a, 64'h222);

        // Flush coinciding with a capture: nothing new appears.
        set_instr(2'b00, 3'b000, 1'b0, 1'b0, 64'h333, 64'h3, 64'h0);
        flush = 1'b1;
        step();
        $display("flush valid=%b a=%0h", out_valid, out_a);
        check("flush_valid", out_valid, 1'b0);
        check("flush_drops_incoming", out_a == 64'h333, 1'b0);
        flush = 1'b0; in_valid = 1'b0;
        step();
        check("flush_after_valid", out_valid, 1'b0);
        check("flush_after_drop", out_a == 64'h333, 1'b0);

        // Illegal combination, then a flush clears the flag.
        set_instr(2'b10, 3'b001, 1'b0, 1'b0, 64'h444, 64'h4, 64'h0);
        in_valid = 1'b1;
        step();
        $display("illegal valid=%b op=%b ill=%b", out_valid, out_alu_op, out_illegal);
        check("illegal_flag", out_illegal, 1'b1);
        check("illegal_op", out_alu_op, 4'b1111);
        in_valid = 1'b0; flush = 1'b1;
        step();
        check("illegal_flush_clears", out_illegal, 1'b0);
        check("illegal_flush_valid", out_valid, 1'b0);
        flush = 1'b0;

        // Drain: valid drops, data holds.
        set_instr(2'b11, 3'b110, 1'b0, 1'b1, 64'h555, 64'h5, 64'h50);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        $display("drain valid=%b a=%0h b=%0h", out_valid, out_a, out_b);
        check("drain_valid", out_valid, 1'b0);
        check("drain_hold_a", out_a, 64'h555);
        check("drain_hold_b", out_b, 64'h50);

`ifdef ID_EX_FWD_EN
        // Forwarding priority at capture, rd=0 sources ignored, then re-evaluation during a stall.
        set_instr(2'b00, 3'b000, 1'b0, 1'b0, 64'h1234, 64'h9, 64'h0);
        in_rs1 = 5'd7; in_rs2 = 5'd2; in_valid = 1'b1;
        fwd_em_we = 1'b1; fwd_em_rd = 5'd7; fwd_em_data = 64'hAA;
        fwd_mw_we = 1'b1; fwd_mw_rd = 5'd7; fwd_mw_data = 64'hBB;
        step();
        $display("fwd both a=%0h", out_a);
        check("fwd_em_wins", out_a, 64'hAA);
        fwd_em_we = 1'b0;
        step();
        check("fwd_mw_only", out_a, 64'hBB);
        fwd_em_we = 1'b1; fwd_em_rd = 5'd0; fwd_mw_rd = 5'd0;
        step();
        check("fwd_rd0_ignored", out_a, 64'h1234);
        fwd_em_we = 1'b0; fwd_mw_we = 1'b0;
        set_instr(2'b10, 3'b000, 1'b0, 1'b0, 64'h10, 64'h20, 64'h0);
        in_rs1 = 5'd9; in_rs2 = 5'd9;
        step();
        out_ready = 1'b0; in_valid = 1'b0;
        fwd_em_we = 1'b1; fwd_em_rd = 5'd9; fwd_em_data = 64'h55;
        step();
        $display("fwd stall a=%0h b=%0h st=%0h", out_a, out_b, out_store_data);
        check("fwd_stall_a", out_a, 64'h55);
        check("fwd_stall_b", out_b, 64'h55);
        check("fwd_stall_store", out_store_data, 64'h55);
        fwd_em_we = 1'b0; fwd_em_rd = 5'd0;
        out_ready = 1'b1;
`endif

        // Reset in the middle of a stall discards the entry; capture resumes right after.
        set_instr(2'b00, 3'b000, 1'b0, 1'b0, 64'h666, 64'h6, 64'h0);
        in_valid = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        #3 reset = 1'b1;
        #1;
        model_reset();
        $display("mid-stall reset valid=%b in_ready=%b a=%0h", out_valid, in_ready, out_a);
        check("midreset_valid", out_valid, 1'b0);
        check("midreset_in_ready", in_ready, 1'b1);
        check("midreset_a", out_a, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        set_instr(2'b01, 3'b000, 1'b0, 1'b0, 64'h777, 64'h7, 64'h0);
        out_ready = 1'b1;
        step();
        check("post_reset_capture_valid", out_valid, 1'b1);
        check("post_reset_capture_a", out_a, 64'h777);

        // Randomized traffic against the model.
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 11) == 0);
            set_instr(2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                      {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
            in_rs1 = 5'($urandom); in_rs2 = 5'($urandom); in_rd = 5'($urandom);
            in_ctrl = 5'($urandom);
            step();
            if (cyc % 50 == 0)
                $display("rnd %0d valid=%b op=%b ill=%b rd=%0d", cyc, out_valid, out_alu_op, out_illegal, out_rd);
            check_model(cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the simple RISC-V core, sitting directly upstream of the 64-bit ALU. It accepts one decoded instruction per cycle from decode and derives the 4-bit ALU operation code from aluop/funct3/funct7. It selects the ALU b operand (register or immediate) and registers everything for the execute stage behind a valid/ready handshake, with stall and flush support.

## Interface
- XLEN, 64, datapath width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_rs1_data, in_rs2_data  in  XLEN  register-file read data
- in_imm  in  XLEN  sign-extended immediate
- in_rs1, in_rs2, in_rd  in  5  register indices
- in_aluop  in  2  00 mem (add), 01 branch (sub), 10 R-type, 11 I-type ALU
- in_funct3  in  3  instruction funct3
- in_funct7_5  in  1  instruction bit 30
- in_alusrc  in  1  1 = b operand is immediate
- in_ctrl  in  5  {branch, memread, memwrite, memtoreg, regwrite}, passed through
- flush  in  1  squash resident and incoming instruction
- out_valid  out  1  execute-stage entry valid
- out_ready  in  1  execute/downstream accepts entry
- out_a, out_b  out  XLEN  ALU operands
- out_alu_op  out  4  ALU operation code
- out_store_data  out  XLEN  rs2 value for stores
- out_rs1, out_rs2, out_rd  out  5  registered indices
- out_ctrl  out  5  registered control bits
- out_illegal  out  1  unsupported aluop/funct combination
- fwd_em_we, fwd_em_rd (5), fwd_em_data (XLEN)  in  EX/MEM writeback source (ID_EX_FWD_EN only)
- fwd_mw_we, fwd_mw_rd (5), fwd_mw_data (XLEN)  in  MEM/WB writeback source (ID_EX_FWD_EN only)

## Operation
- Single-entry register. in_ready = !out_valid || out_ready (combinational).
- Capture: in_valid && in_ready && !flush at a rising edge. Sets out_valid and loads all out_* fields.
- Drain: out_valid && out_ready with no capture -> out_valid clears; data fields hold their last value.
- Stall: out_valid && !out_ready -> all outputs hold (operands may update only via forwarding, see Configuration).
- Flush: out_valid = 0 and out_illegal = 0 next edge; the incoming instruction is dropped. Flush wins over capture and over stall.
- ALU op decode (registered with the entry):
  - aluop 00 -> 0010 (add)
  - aluop 01 -> 0110 (sub)
  - aluop 10: funct3 000 with funct7_5=0 -> 0010; funct3 000 with funct7_5=1 -> 0110; funct3 111 -> 0000; funct3 110 -> 0001
  - aluop 11: funct3 000 -> 0010 (funct7_5 ignored); funct3 111 -> 0000; funct3 110 -> 0001
  - Any other combination: alu_op = 1111 and out_illegal = 1; the ALU then yields 0.
- Operands:
  - out_a = rs1 value.
  - out_b = in_alusrc ? in_imm : rs2 value.
  - out_store_data = rs2 value, even when alusrc = 1.
- No arithmetic in this block; widths pass through unchanged.

## Timing
- Latency is 1 cycle from capture edge to out_valid; throughput is 1 instruction per cycle when out_ready is held high.
- Reset (async assert, takes effect immediately): out_valid = 0, out_illegal = 0, out_alu_op = 0000, out_ctrl = 0, all data and index outputs = 0. in_ready = 1 during and after reset.
- Reset asserted mid-stall discards the entry. First capture is possible on the first edge after deassertion.
- Capture and drain on the same edge: the new entry replaces the old one and out_valid stays 1.

## Configuration
- ID_EX_FWD_EN defined:
  - The fwd_* ports exist.
  - The rs1 and rs2 values are forwarded at capture: the EX/MEM source wins over MEM/WB. A source matches when we = 1, rd != 0 and rd equals the index.
  - While stalled, the held rs1/rs2-derived operands (out_a, out_store_data, and out_b when alusrc = 0) are re-evaluated against the fwd sources each cycle using out_rs1/out_rs2. The same priority applies.
- ID_EX_FWD_EN undefined:
  - The fwd_* ports are absent.
  - Operands come only from in_rs1_data and in_rs2_data.
  - Held operands never change during a stall.

## Test plan
- Reset, then one R-type capture: rs1_data=5, rs2_data=3, aluop=10, funct3=000, funct7_5=1 -> next cycle out_valid=1, out_a=5, out_b=3, out_alu_op=0110.
- I-type capture with alusrc=1, imm=64'hFFFF_FFFF_FFFF_FFF0, funct3=111 -> out_b=imm, out_alu_op=0000, out_store_data=rs2_data.
- Stall: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and the entry holds; out_ready=1 -> the next instruction is captured on that same edge and out_valid stays 1.
- Flush on the same edge as a capture -> out_valid=0 next cycle and the incoming instruction never appears on the outputs.
- aluop=10, funct3=001 -> out_illegal=1, out_alu_op=1111; a following flush clears out_illegal.
- (ID_EX_FWD_EN) in_rs1=7, both fwd sources have rd=7 (em data 0xAA, mw data 0xBB) -> out_a=0xAA. With rd=0 on both sources -> out_a=in_rs1_data.
